// File: rtl/pdp_reg_pkg.sv
// Shared definitions for the PDP ping-pong register-group controller:
// group status encodings, group count and the status encode helper.
package pdp_reg_pkg;

    localparam logic [1:0] PDP_GRP_IDLE    = 2'd0;
    localparam logic [1:0] PDP_GRP_RUNNING = 2'd1;
    localparam logic [1:0] PDP_GRP_PENDING = 2'd2;

    localparam int PDP_NUM_GROUPS = 2;

    // An enabled group is RUNNING when the datapath owns it, otherwise PENDING.
    function automatic logic [1:0] pdp_grp_status(input logic op_en, input logic is_consumer);
        if (!op_en)
            return PDP_GRP_IDLE;
        return is_consumer ? PDP_GRP_RUNNING : PDP_GRP_PENDING;
    endfunction

endpackage

// File: rtl/pdp_reg_group_ctrl_if.sv
// Register-side bundle between the PDP single-register block, software
// readback and the datapath; the controller uses the slave view.
interface pdp_reg_group_ctrl_if #(
    parameter int DONE_CNT_W = 16
);
    logic                  producer;
    logic                  op_en_trigger;
    logic                  op_en_wdata;
    logic                  dp2reg_done;
    logic                  consumer;
    logic [1:0]            status_0;
    logic [1:0]            status_1;
    logic                  d0_op_en;
    logic                  d1_op_en;
    logic                  reg2dp_op_en;
    logic [1:0]            intr_done;
    logic [DONE_CNT_W-1:0] d0_done_cnt;
    logic [DONE_CNT_W-1:0] d1_done_cnt;

    modport slave (
        input  producer, op_en_trigger, op_en_wdata, dp2reg_done,
        output consumer, status_0, status_1, d0_op_en, d1_op_en,
               reg2dp_op_en, intr_done, d0_done_cnt, d1_done_cnt
    );

    modport master (
        output producer, op_en_trigger, op_en_wdata, dp2reg_done,
        input  consumer, status_0, status_1, d0_op_en, d1_op_en,
               reg2dp_op_en, intr_done, d0_done_cnt, d1_done_cnt
    );

endinterface

// File: rtl/pdp_reg_group_slot.sv
// One register group: op_en flag with software set / datapath retire,
// saturating completed-op counter and status encode.
module pdp_reg_group_slot
    import pdp_reg_pkg::*;
#(
    parameter int DONE_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_set,
    input  logic                  i_retire,
    input  logic                  i_is_consumer,
    output logic                  o_op_en,
    output logic [1:0]            o_status,
    output logic [DONE_CNT_W-1:0] o_done_cnt
);

    logic                  r_op_en;
    logic [DONE_CNT_W-1:0] r_done_cnt;

    // Retire wins over a same-cycle set: the group was enabled, so the set is a no-op anyway.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_op_en    <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            if (i_retire)
                r_op_en <= 1'b0;
            else if (i_set)
                r_op_en <= 1'b1;
            if (i_retire && (r_done_cnt != {DONE_CNT_W{1'b1}}))
                r_done_cnt <= r_done_cnt + 1'b1;
        end
    end

    assign o_op_en    = r_op_en;
    assign o_done_cnt = r_done_cnt;
    assign o_status   = pdp_grp_status(r_op_en, i_is_consumer);

endmodule

// File: rtl/pdp_reg_group_ctrl.sv
// Ping-pong register-group controller: tracks which group the datapath owns,
// drives the registered op enable and pulses per-group done interrupts.
module pdp_reg_group_ctrl
    import pdp_reg_pkg::*;
#(
    parameter int DONE_CNT_W = 16
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    pdp_reg_group_ctrl_if.slave  regs
);

    logic                      r_consumer;
    logic                      r_reg2dp_op_en;
    logic [PDP_NUM_GROUPS-1:0] r_intr_done;

    logic                      w_retire;
    logic [PDP_NUM_GROUPS-1:0] w_set;
    logic [PDP_NUM_GROUPS-1:0] w_retire_grp;
    logic [PDP_NUM_GROUPS-1:0] w_op_en;
    logic [DONE_CNT_W-1:0]     w_cnt0;
    logic [DONE_CNT_W-1:0]     w_cnt1;
    logic [1:0]                w_status0;
    logic [1:0]                w_status1;

    // A done only counts while the datapath was actually enabled; stray dones vanish here.
    assign w_retire        = regs.dp2reg_done & r_reg2dp_op_en;
    assign w_set[0]        = regs.op_en_trigger & regs.op_en_wdata & ~regs.producer;
    assign w_set[1]        = regs.op_en_trigger & regs.op_en_wdata &  regs.producer;
    assign w_retire_grp[0] = w_retire & ~r_consumer;
    assign w_retire_grp[1] = w_retire &  r_consumer;

    pdp_reg_group_slot #(.DONE_CNT_W(DONE_CNT_W)) u_slot0 (
        .i_clk         (nvdla_core_clk),
        .i_rstn        (nvdla_core_rstn),
        .i_set         (w_set[0]),
        .i_retire      (w_retire_grp[0]),
        .i_is_consumer (~r_consumer),
        .o_op_en       (w_op_en[0]),
        .o_status      (w_status0),
        .o_done_cnt    (w_cnt0)
    );

    pdp_reg_group_slot #(.DONE_CNT_W(DONE_CNT_W)) u_slot1 (
        .i_clk         (nvdla_core_clk),
        .i_rstn        (nvdla_core_rstn),
        .i_set         (w_set[1]),
        .i_retire      (w_retire_grp[1]),
        .i_is_consumer (r_consumer),
        .o_op_en       (w_op_en[1]),
        .o_status      (w_status1),
        .o_done_cnt    (w_cnt1)
    );

    // Forcing op enable low on done guarantees a one-cycle gap before the next group starts.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_consumer     <= 1'b0;
            r_reg2dp_op_en <= 1'b0;
            r_intr_done    <= '0;
        end else begin
            r_reg2dp_op_en <= regs.dp2reg_done ? 1'b0 : w_op_en[r_consumer];
            r_intr_done    <= w_retire_grp;
            if (w_retire)
                r_consumer <= ~r_consumer;
        end
    end

    assign regs.consumer     = r_consumer;
    assign regs.reg2dp_op_en = r_reg2dp_op_en;
    assign regs.intr_done    = r_intr_done;
    assign regs.d0_op_en     = w_op_en[0];
    assign regs.d1_op_en     = w_op_en[1];
    assign regs.status_0     = w_status0;
    assign regs.status_1     = w_status1;
    assign regs.d0_done_cnt  = w_cnt0;
    assign regs.d1_done_cnt  = w_cnt1;

endmodule
